// File: rtl/register_uart_tx.sv
// register_uart_tx: bus-mapped 8N1 serial transmitter with a byte FIFO.
// Bytes written to TX_INDEX are queued and shifted out LSB first on uart_tx.
//
// Ports:
//   clk                  system clock, rising edge
//   reset_n              async active-low reset
//   register_index       peripheral register index
//   register_read        read strobe
//   register_write       write strobe
//   register_write_value write data
//   register_read_value  combinational read data, 0 if unselected
//   uart_tx              serial line, idle high
module register_uart_tx #(
  parameter int          FIFO_DEPTH      = 8,
  parameter logic [15:0] DEFAULT_DIVISOR = 16'd434,
  parameter logic [6:0]  TX_INDEX        = 7'd0,
  parameter logic [6:0]  STATUS_INDEX    = 7'd2,
  parameter logic [6:0]  DIVISOR_INDEX   = 7'd3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [6:0]  register_index,
  input  logic        register_read,
  input  logic        register_write,
  input  logic [15:0] register_write_value,
  output logic [15:0] register_read_value,
  output logic        uart_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   divisor;
  logic          overflow;

  state_t        state;
  state_t        state_n;
  logic [15:0]   cnt;
  logic [15:0]   cnt_n;
  logic [15:0]   frame_div;
  logic [15:0]   frame_div_n;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_n;
  logic [7:0]    shreg;
  logic [7:0]    shreg_n;
  logic          tx;
  logic          tx_n;
  logic          pop;
  logic          start;

  logic full;
  logic empty;
  logic busy;
  logic push;
  logic push_ok;
  logic ovf_set;
  logic stat_rd;
  logic div_wr;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign busy    = (state != IDLE);
  assign push    = register_write && (register_index == TX_INDEX);
  assign div_wr  = register_write && (register_index == DIVISOR_INDEX);
  assign stat_rd = register_read && (register_index == STATUS_INDEX);
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign uart_tx = tx;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= register_write_value[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      divisor  <= DEFAULT_DIVISOR;
      overflow <= 1'b0;
    end else begin
      if (div_wr) begin
        divisor <= (register_write_value < 16'd2) ?
                   16'd2 : register_write_value;
      end
      // A fresh overflow beats the read-to-clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (stat_rd) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      frame_div <= DEFAULT_DIVISOR;
      bit_idx   <= '0;
      shreg     <= '0;
      tx        <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      frame_div <= frame_div_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      tx        <= tx_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    frame_div_n = frame_div;
    bit_idx_n   = bit_idx;
    shreg_n     = shreg;
    tx_n        = tx;
    pop         = 1'b0;
    start       = 1'b0;
    unique case (state)
      IDLE: begin
        start = !empty;
      end
      START: begin
        if (cnt == '0) begin
          tx_n      = shreg[0];
          bit_idx_n = '0;
          cnt_n     = frame_div - 16'd1;
          state_n   = DATA;
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = frame_div - 16'd1;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shreg_n   = shreg >> 1;
            tx_n      = shreg[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      STOP: begin
        if (cnt == '0) begin
          // Chain straight into the next start bit when data waits.
          if (!empty) begin
            start = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // Frame start: divisor is latched so mid-frame writes wait.
    if (start) begin
      pop         = 1'b1;
      shreg_n     = mem[rd_ptr];
      frame_div_n = divisor;
      cnt_n       = divisor - 16'd1;
      tx_n        = 1'b0;
      state_n     = START;
    end
  end

  always_comb begin
    register_read_value = '0;
    if (register_read) begin
      unique case (1'b1)
        (register_index == STATUS_INDEX): begin
          register_read_value = {8'(count), 4'b0,
                                 overflow, busy, empty, full};
        end
        (register_index == DIVISOR_INDEX): begin
          register_read_value = divisor;
        end
        default: begin
          register_read_value = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_register_uart_tx.sv
// tb_register_uart_tx: directed bench for register_uart_tx.
// A line monitor decodes frames and checks them against a queue.
module tb_register_uart_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  register_index = '0;
  logic        register_read = 1'b0;
  logic        register_write = 1'b0;
  logic [15:0] register_write_value = '0;
  logic [15:0] register_read_value;
  logic        uart_tx;

  always #5 clk = ~clk;

  register_uart_tx dut (
    .clk                  (clk),
    .reset_n              (reset_n),
    .register_index       (register_index),
    .register_read        (register_read),
    .register_write       (register_write),
    .register_write_value (register_write_value),
    .register_read_value  (register_read_value),
    .uart_tx              (uart_tx)
  );

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t   sb[$];
  longint starts[$];
  longint cyc = 0;
  bit     mon_act = 1'b0;
  int     n_checks = 0;
  int     n_errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin : mon
    exp_t       e;
    int         off;
    logic [9:0] rx;
    e.data = '0;
    e.div  = 2;
    off    = 0;
    rx     = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mon_act = 1'b0;
      end else if (!mon_act) begin
        if (uart_tx === 1'b0) begin
          chk("frame_expected", 16'(sb.size() > 0), 16'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            mon_act = 1'b1;
            off = 0;
            rx = '0;
            starts.push_back(cyc);
          end
        end
      end else begin
        off++;
        if (off % e.div == e.div / 2) rx[off / e.div] = uart_tx;
        if (off == 9 * e.div + e.div / 2)
          chk("frame_bits", 16'(rx), {6'b0, 1'b1, e.data, 1'b0});
        if (off == 10 * e.div - 1) mon_act = 1'b0;
      end
    end
  end

  task automatic wr(input logic [6:0] idx, input logic [15:0] val);
    @(negedge clk);
    register_index = idx;
    register_write_value = val;
    register_write = 1'b1;
    @(posedge clk);
    #1 register_write = 1'b0;
  endtask

  task automatic rd(input logic [6:0] idx,
                    input logic [15:0] exp,
                    input string tag);
    @(negedge clk);
    register_index = idx;
    register_read = 1'b1;
    #1 chk(tag, register_read_value, exp);
    @(posedge clk);
    #1 register_read = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int div);
    exp_t e;
    e.data = b;
    e.div = div;
    sb.push_back(e);
    wr(7'd0, {8'hA5, b});
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() > 0 || mon_act) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 16'(n < 5000), 16'd1);
  endtask

  initial begin
    int lows;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_tx_high", uart_tx, 1'b1);
    rd(7'd2, 16'h0002, "rst_status");
    rd(7'd3, 16'd434, "rst_div");

    wr(7'd3, 16'd4);
    rd(7'd3, 16'd4, "div4_readback");
    send(8'h41, 4);
    chk("tx_high_at_write", uart_tx, 1'b1);
    @(posedge clk);
    #1 chk("start_bit_low", uart_tx, 1'b0);
    repeat (39) @(posedge clk);
    rd(7'd2, 16'h0006, "busy_in_stop");
    chk("tx_high_after_frame", uart_tx, 1'b1);
    rd(7'd2, 16'h0002, "idle_after_frame");
    wait_drain("drain_single");

    starts.delete();
    send(8'h2F, 4);
    for (int i = 0; i < 8; i++) send(8'(8'h30 + i), 4);
    wr(7'd0, 16'h0038);
    rd(7'd2, 16'h080D, "status_full_ovf");
    rd(7'd2, 16'h0805, "ovf_cleared");
    wait_drain("drain_burst");
    chk("burst_frames", 16'(starts.size()), 16'd9);
    if (starts.size() == 9)
      chk("burst_gapless", 16'(starts[8] - starts[0]), 16'd320);

    wr(7'd3, 16'd0);
    rd(7'd3, 16'd2, "div_min_clamp");
    wr(7'd3, 16'd4);
    starts.delete();
    send(8'h55, 4);
    send(8'hA3, 8);
    wr(7'd3, 16'd8);
    rd(7'd3, 16'd8, "div8_readback");
    wait_drain("drain_divchg");
    chk("divchg_frames", 16'(starts.size()), 16'd2);
    if (starts.size() == 2)
      chk("divchg_next_frame", 16'(starts[1] - starts[0]), 16'd40);

    send(8'h00, 8);
    wr(7'd0, 16'h0011);
    wr(7'd0, 16'h0022);
    wr(7'd0, 16'h0033);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("tx_low_mid_data", uart_tx, 1'b0);
    reset_n = 1'b0;
    #1 chk("tx_async_high", uart_tx, 1'b1);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd(7'd2, 16'h0002, "status_after_reset");
    rd(7'd3, 16'd434, "div_after_reset");
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lows++;
    end
    chk("no_frames_after_reset", 16'(lows), 16'd0);

    rd(7'd1, 16'h0000, "idx1_read_zero");
    rd(7'd5, 16'h0000, "idx5_read_zero");
    rd(7'd0, 16'h0000, "tx_idx_read_zero");
    @(negedge clk);
    register_index = 7'd2;
    register_read = 1'b0;
    #1 chk("no_strobe_zero", register_read_value, 16'h0000);
    wr(7'd1, 16'h00FF);
    rd(7'd2, 16'h0002, "idx1_write_status");
    rd(7'd3, 16'd434, "idx1_write_div");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
